// File: rtl/psb_bus_arbiter.sv
// psb_bus_arbiter: round-robin PSB address arbiter with queued, in-order data tenure grants
module psb_bus_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int QDEPTH        = 2,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_MASTERS-1:0] PSB_br_n,
    output logic [NUM_MASTERS-1:0] PSB_bg_n,
    output logic [NUM_MASTERS-1:0] PSB_dbg_n,
    input  logic                   PSB_ts_n,
    input  logic                   PSB_abb_n,
    input  logic                   PSB_aack_n,
    input  logic                   PSB_artry_n,
    input  logic [0:4]             PSB_tt,
    input  logic                   PSB_tbst_n,
    input  logic                   PSB_dbb_n,
    input  logic                   PSB_ta_n,
    input  logic                   PSB_tea_n,
    output logic [1:0]             arb_addr_owner,
    output logic [1:0]             arb_data_owner,
    output logic [2:0]             arb_q_level,
    output logic                   arb_timeout
);
    localparam int TW = $clog2(GRANT_TIMEOUT + 1);
    localparam int QW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;

    typedef enum logic [1:0] {A_IDLE, A_GRANT, A_TENURE, A_ACK} a_state_t;
    typedef enum logic [1:0] {D_IDLE, D_GRANT, D_BUSY} d_state_t;

    a_state_t a_state, a_next;
    d_state_t d_state, d_next;
    logic [NUM_MASTERS-1:0] req, bg_next, dbg_next;
    logic [1:0] rr_ptr, rr_next, a_own_next, d_own_next, win, own_inc, head_owner;
    logic win_ok, owner_req, q_full, push, pop;
    logic [TW-1:0] tmo_cnt, tmo_next;
    logic tmo_pulse, rec_data, rec_burst, rec_data_next, rec_burst_next;
    logic d_burst, d_burst_next, head_burst;
    logic [2:0] beat, beat_next;
    logic [1:0] q_owner [QDEPTH];
    logic q_burst [QDEPTH];
    logic [QW-1:0] wr_ptr, rd_ptr;
    int idx;
    logic tt_unused;

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == QW'(QDEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    assign tt_unused  = ^{PSB_tt[0:2], PSB_tt[4]};
    assign req        = ~PSB_br_n;
    assign owner_req  = |(req & (NUM_MASTERS'(1) << arb_addr_owner));
    assign own_inc    = (arb_addr_owner == 2'(NUM_MASTERS - 1)) ? 2'd0 : arb_addr_owner + 2'd1;
    assign q_full     = arb_q_level == 3'(QDEPTH);
    assign head_owner = q_owner[rd_ptr];
    assign head_burst = q_burst[rd_ptr];

    // first requester at or after the round-robin pointer
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        idx    = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (|(req & (NUM_MASTERS'(1) << idx))) begin
                win    = 2'(idx);
                win_ok = 1'b1;
            end
        end
    end

    // address tenure next state: grant, ts/withdraw/timeout, aack, artry window
    always_comb begin
        a_next         = a_state;
        bg_next        = PSB_bg_n;
        a_own_next     = arb_addr_owner;
        rr_next        = rr_ptr;
        tmo_next       = tmo_cnt;
        tmo_pulse      = 1'b0;
        rec_data_next  = rec_data;
        rec_burst_next = rec_burst;
        push           = 1'b0;
        case (a_state)
            A_IDLE: if (win_ok && PSB_abb_n && !q_full) begin
                bg_next    = ~(NUM_MASTERS'(1) << win);
                a_own_next = win;
                tmo_next   = '0;
                a_next     = A_GRANT;
            end
            A_GRANT: begin
                tmo_next = tmo_cnt + TW'(1);
                if (!PSB_ts_n) begin
                    bg_next        = '1;
                    rec_data_next  = PSB_tt[3];
                    rec_burst_next = !PSB_tbst_n;
                    a_next         = A_TENURE;
                end else if (!owner_req) begin
                    bg_next = '1;
                    a_next  = A_IDLE;
                end else if (tmo_cnt == TW'(GRANT_TIMEOUT - 1)) begin
                    bg_next   = '1;
                    tmo_pulse = 1'b1;
                    rr_next   = own_inc;
                    a_next    = A_IDLE;
                end
            end
            A_TENURE: a_next = PSB_aack_n ? A_TENURE : A_ACK;
            A_ACK: begin
                push    = PSB_artry_n && rec_data;
                rr_next = own_inc;
                a_next  = A_IDLE;
            end
            default: a_next = A_IDLE;
        endcase
    end

    // address tenure state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_state        <= A_IDLE;
            PSB_bg_n       <= '1;
            arb_addr_owner <= '0;
            rr_ptr         <= '0;
            tmo_cnt        <= '0;
            arb_timeout    <= 1'b0;
            rec_data       <= 1'b0;
            rec_burst      <= 1'b0;
        end else begin
            a_state        <= a_next;
            PSB_bg_n       <= bg_next;
            arb_addr_owner <= a_own_next;
            rr_ptr         <= rr_next;
            tmo_cnt        <= tmo_next;
            arb_timeout    <= tmo_pulse;
            rec_data       <= rec_data_next;
            rec_burst      <= rec_burst_next;
        end
    end

    // data tenure next state: grant queue head, wait dbb, count beats until done or error
    always_comb begin
        d_next       = d_state;
        dbg_next     = PSB_dbg_n;
        d_own_next   = arb_data_owner;
        d_burst_next = d_burst;
        beat_next    = beat;
        pop          = 1'b0;
        case (d_state)
            D_IDLE: if (arb_q_level != 3'd0 && PSB_dbb_n) begin
                dbg_next     = ~(NUM_MASTERS'(1) << head_owner);
                d_own_next   = head_owner;
                d_burst_next = head_burst;
                d_next       = D_GRANT;
            end
            D_GRANT: if (!PSB_dbb_n) begin
                dbg_next  = '1;
                beat_next = '0;
                d_next    = D_BUSY;
            end
            D_BUSY: begin
                beat_next = PSB_ta_n ? beat : beat + 3'd1;
                if (!PSB_tea_n || (!PSB_ta_n && beat_next == (d_burst ? 3'd4 : 3'd1))) begin
                    pop    = 1'b1;
                    d_next = D_IDLE;
                end
            end
            default: d_next = D_IDLE;
        endcase
    end

    // data tenure state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_state        <= D_IDLE;
            PSB_dbg_n      <= '1;
            arb_data_owner <= '0;
            d_burst        <= 1'b0;
            beat           <= '0;
        end else begin
            d_state        <= d_next;
            PSB_dbg_n      <= dbg_next;
            arb_data_owner <= d_own_next;
            d_burst        <= d_burst_next;
            beat           <= beat_next;
        end
    end

    // in-order queue of acknowledged data tenures
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            arb_q_level <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_owner[i] <= '0;
                q_burst[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                q_owner[wr_ptr] <= arb_addr_owner;
                q_burst[wr_ptr] <= rec_burst;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            arb_q_level <= arb_q_level + 3'(push) - 3'(pop);
        end
    end
endmodule
